// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-clock frame, ack check.
// Optional macro PS2_TX_RETRY_EN: up to 3 attempts per byte before the error pulse.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAITIDLE, S_DONE, S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic [7:0]             data_q, data_d;
    logic                   par_q, par_d;
    logic [3:0]             bit_q, bit_d;
    logic [IW-1:0]          inh_q, inh_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   clk_oe_q, clk_oe_d;
    logic                   dat_oe_q, dat_oe_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   clk_s, dat_s, fall, fail;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]             retry_q, retry_d;
`endif

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_prev_q & ~clk_s;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            data_q     <= '0;
            par_q      <= 1'b0;
            bit_q      <= '0;
            inh_q      <= '0;
            tmo_q      <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            clk_sync_q[0] <= ps2_clk_in;
            dat_sync_q[0] <= ps2_dat_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i] <= clk_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
            end
            clk_prev_q <= clk_s;
            state_q    <= state_d;
            data_q     <= data_d;
            par_q      <= par_d;
            bit_q      <= bit_d;
            inh_q      <= inh_d;
            tmo_q      <= tmo_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        bit_d    = bit_q;
        inh_d    = inh_q;
        tmo_d    = tmo_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                data_d   = cmd_data;
                par_d    = ~^cmd_data;
                bit_d    = '0;
                inh_d    = '0;
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
                retry_d  = '0;
`endif
                state_d  = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    inh_d = inh_q + IW'(1);
                end
            end
            S_REQ: begin
                clk_oe_d = 1'b0;
                tmo_d    = '0;
                bit_d    = '0;
                state_d  = S_SHIFT;
            end
            // bit_q counts falls already seen; fall 10 releases data for the stop bit
            S_SHIFT: if (fall) begin
                bit_d = bit_q + 4'd1;
                if (bit_q < 4'd8) begin
                    dat_oe_d = ~data_q[bit_q[2:0]];
                end else if (bit_q == 4'd8) begin
                    dat_oe_d = ~par_q;
                end else begin
                    dat_oe_d = 1'b0;
                    state_d  = S_ACK;
                end
            end
            S_ACK: if (fall) begin
                if (dat_s) fail = 1'b1;
                else       state_d = S_WAITIDLE;
            end
            S_WAITIDLE: if (clk_s && dat_s) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_q inside {S_SHIFT, S_ACK, S_WAITIDLE}) begin
            if (tmo_q == TMO_LAST) fail = 1'b1;
            else                   tmo_d = tmo_q + TW'(1);
        end

        // Any failure releases both lines on the same edge and suppresses done
        if (fail) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q < 2'd2) begin
                retry_d  = retry_q + 2'd1;
                inh_d    = '0;
                clk_oe_d = 1'b1;
                state_d  = S_INHIBIT;
            end else begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end
`else
            err_d   = 1'b1;
            state_d = S_ERR;
`endif
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on wired-AND pins, frame model from byte arithmetic.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 600;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic       dev_clk, dev_dat;
    logic       ps2_clk_in, ps2_dat_in;

    int vec = 0, miss = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, clk_low_cnt = 0;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) inh_cnt++;
        if (ps2_clk_oe === 1'b1) clk_low_cnt++;
    end

    // Expected 11-bit frame as seen on the wire: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!(ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0)) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin ok = 1'b0; return; end
        end
    endtask

    // Device side: waits for request-to-send, clocks 11 times, samples before each rise
    task automatic dev_xfer(input int half, input bit ack, output logic [10:0] frm, output bit ok);
        frm = '0;
        wait_req(ok);
        if (!ok) return;
        repeat (half) @(negedge clk);
        frm[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            frm[k]  = ps2_dat_in;
            dev_clk = 1'b1;
            repeat (half) @(negedge clk);
        end
        if (ack) dev_dat = 1'b0;
        repeat (half) @(negedge clk);
        dev_clk = 1'b0;
        repeat (half) @(negedge clk);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk);
        dev_dat = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (busy !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin ok = 1'b0; return; end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_data = '0; dev_clk = 1'b1; dev_dat = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        vec++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin miss++; $display("FAIL reset_oe got=%b exp=00", {ps2_clk_oe, ps2_dat_oe}); end
        vec++; if ({done, error} !== 2'b00) begin miss++; $display("FAIL reset_pulses got=%b exp=00", {done, error}); end
        vec++; if ({busy, cmd_ready} !== 2'b01) begin miss++; $display("FAIL reset_busy_ready got=%b exp=01", {busy, cmd_ready}); end
    endtask

    task automatic test_ed;
        logic [10:0] f; bit ok, ok2;
        int d0, e0, i0, c0;
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; c0 = clk_low_cnt;
        send(8'hED);
        dev_xfer(8, 1'b1, f, ok);
        wait_idle(ok2);
        vec++; if (!(ok && ok2)) begin miss++; $display("FAIL ed_timeout got=%0b%0b exp=11", ok, ok2); end
        vec++; if (f !== 11'b1_1_11101101_0) begin miss++; $display("FAIL ed_frame got=%b exp=%b", f, 11'b1_1_11101101_0); end
        vec++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miss++; $display("FAIL ed_pulses got done=%0d err=%0d exp 1 0", done_cnt - d0, err_cnt - e0); end
        vec++; if (inh_cnt - i0 !== INH) begin miss++; $display("FAIL ed_inhibit got=%0d exp=%0d", inh_cnt - i0, INH); end
        vec++; if (clk_low_cnt - c0 !== INH + 1) begin miss++; $display("FAIL ed_clk_low got=%0d exp=%0d", clk_low_cnt - c0, INH + 1); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL ed_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_parity;
        logic [7:0] bytes [2];
        logic [10:0] f; bit ok, ok2;
        bytes[0] = 8'hF4; bytes[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            send(bytes[i]);
            dev_xfer(7, 1'b1, f, ok);
            wait_idle(ok2);
            vec++; if (!(ok && ok2)) begin miss++; $display("FAIL par_timeout byte=%h", bytes[i]); end
            vec++; if (f[9] !== (i == 0 ? 1'b0 : 1'b1)) begin miss++; $display("FAIL par_bit byte=%h got=%b exp=%b", bytes[i], f[9], (i == 0 ? 1'b0 : 1'b1)); end
            vec++; if (f !== exp_frame(bytes[i])) begin miss++; $display("FAIL par_frame got=%b exp=%b", f, exp_frame(bytes[i])); end
        end
    endtask

    task automatic test_nack;
        logic [10:0] f; logic [7:0] b; bit ok, ok2;
        int d0, e0, i0;
        b = 8'($urandom);
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        send(b);
        for (int a = 0; a < ATTEMPTS; a++) begin
            dev_xfer(8, 1'b0, f, ok);
            vec++; if (!ok || f !== exp_frame(b)) begin miss++; $display("FAIL nack_frame attempt=%0d got=%b exp=%b", a, f, exp_frame(b)); end
        end
        wait_idle(ok2);
        vec++; if (!ok2 || done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin miss++; $display("FAIL nack_pulses got done=%0d err=%0d exp 0 1", done_cnt - d0, err_cnt - e0); end
        vec++; if (inh_cnt - i0 !== ATTEMPTS * INH) begin miss++; $display("FAIL nack_inhibits got=%0d exp=%0d", inh_cnt - i0, ATTEMPTS * INH); end
        vec++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin miss++; $display("FAIL nack_release got=%b exp=00", {ps2_clk_oe, ps2_dat_oe}); end
    endtask

    task automatic test_timeout;
        int n = -1, t = 0, d0;
        logic prev = 1'b1;
        bit seen = 1'b0;
        d0 = done_cnt;
        send(8'h5A);
        while (t < 5000) begin
            if (prev === 1'b1 && ps2_clk_oe === 1'b0) n = 0;
            else if (n >= 0) n++;
            if (error === 1'b1) begin seen = 1'b1; break; end
            prev = ps2_clk_oe;
            @(negedge clk);
            t++;
        end
        vec++; if (!seen || n !== TMO) begin miss++; $display("FAIL tmo_latency got=%0d seen=%0b exp=%0d", n, seen, TMO); end
        vec++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin miss++; $display("FAIL tmo_release got=%b exp=00", {ps2_clk_oe, ps2_dat_oe}); end
        @(negedge clk);
        vec++; if (busy !== 1'b0 || done_cnt !== d0) begin miss++; $display("FAIL tmo_end got busy=%b done=%0d exp 0 %0d", busy, done_cnt, d0); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b; bit ok;
        int d0, e0;
        b = 8'hA5; d0 = done_cnt; e0 = err_cnt;
        send(b);
        wait_req(ok);
        repeat (8) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            dev_clk = 1'b0;
            repeat (8) @(negedge clk);
            if (k < 4) begin dev_clk = 1'b1; repeat (8) @(negedge clk); end
        end
        vec++; if (!ok || ps2_dat_oe !== ~b[3]) begin miss++; $display("FAIL mid_bit3 got=%b exp=%b", ps2_dat_oe, ~b[3]); end
        resetn = 1'b0;
        @(negedge clk);
        vec++; if ({ps2_clk_oe, ps2_dat_oe, busy, cmd_ready} !== 4'b0001) begin miss++; $display("FAIL mid_reset got=%b exp=0001", {ps2_clk_oe, ps2_dat_oe, busy, cmd_ready}); end
        resetn = 1'b1; dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        vec++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || busy !== 1'b0) begin miss++; $display("FAIL mid_no_pulse got done=%0d err=%0d busy=%b exp 0 0 0", done_cnt - d0, err_cnt - e0, busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b; logic [10:0] f; bit ok, ok2; int n, d0;
        a = 8'($urandom); b = ~a; d0 = done_cnt;
        @(negedge clk);
        cmd_data = a; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_data = b;
        dev_xfer(8, 1'b1, f, ok);
        vec++; if (!ok || f !== exp_frame(a)) begin miss++; $display("FAIL b2b_first got=%b exp=%b", f, exp_frame(a)); end
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        vec++; if (cmd_ready !== 1'b1 || done_cnt - d0 !== 1) begin miss++; $display("FAIL b2b_ready_after_done got ready=%b done=%0d exp 1 1", cmd_ready, done_cnt - d0); end
        @(negedge clk);
        cmd_valid = 1'b0;
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL b2b_second_start got=%b exp=1", busy); end
        dev_xfer(8, 1'b1, f, ok);
        wait_idle(ok2);
        vec++; if (!(ok && ok2) || f !== exp_frame(b)) begin miss++; $display("FAIL b2b_second got=%b exp=%b", f, exp_frame(b)); end
        vec++; if (done_cnt - d0 !== 2) begin miss++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
    endtask

    task automatic test_random;
        logic [7:0] b; logic [10:0] f; bit ack, ok, ok2; int half, d0, e0;
        for (int it = 0; it < 10; it++) begin
            b = 8'($urandom); half = $urandom_range(5, 12); ack = ($urandom_range(0, 3) != 0);
            d0 = done_cnt; e0 = err_cnt;
            send(b);
            for (int a = 0; a < (ack ? 1 : ATTEMPTS); a++) begin
                dev_xfer(half, ack, f, ok);
                vec++; if (!ok || f !== exp_frame(b)) begin miss++; $display("FAIL rnd_frame it=%0d got=%b exp=%b", it, f, exp_frame(b)); end
            end
            wait_idle(ok2);
            vec++; if (!ok2 || done_cnt - d0 !== (ack ? 1 : 0) || err_cnt - e0 !== (ack ? 0 : 1)) begin
                miss++; $display("FAIL rnd_pulses it=%0d got done=%0d err=%0d ack=%0b", it, done_cnt - d0, err_cnt - e0, ack);
            end
        end
    endtask

    initial begin
        test_reset;
        test_ed;
        test_parity;
        test_nack;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_random;
        vec++; if (both_cnt !== 0) begin miss++; $display("FAIL done_and_error got=%0d exp=0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
